gfx_interp_pipe: RTL and testbench
==================================

Name: gfx_interp_pipe

Overview:
- Fully pipelined barycentric interpolator.
- Successor to the single-issue color/UV/Z interpolation stage: one pixel per clock, an arbitrary number of generic attribute channels, per-channel signedness, saturation and valid/ready back-pressure.
- Sits between the triangle rasteriser/divider, which supplies factors and x/y, and the fragment processor, which consumes the interpolated attributes.
- Color splitting/packing stays outside this block. Each color component is one channel.

Parameters:
- POINT_WIDTH, 16: width of factor0_i/factor1_i, x, y. Factors are unsigned fractions of 2^POINT_WIDTH.
- ATTR_CHANNELS, 4: number of interpolated channels (1..16).
- ATTR_WIDTH, 16: width of each channel value (1..32).
- ATTR_SIGNED, 0: bitmask. Bit k=1 means channel k is two's-complement (e.g. Z); 0 means unsigned.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  asynchronous, active-high reset
- flush_i  in  1  synchronous flush: drops all in-flight pixels
- in_valid_i  in  1  input pixel valid
- in_ready_o  out  1  block accepts the input this cycle
- factor0_i  in  POINT_WIDTH  barycentric weight of vertex 0
- factor1_i  in  POINT_WIDTH  barycentric weight of vertex 1
- x_i, y_i  in  POINT_WIDTH each  raster position, passed through
- attr0_i, attr1_i, attr2_i  in  ATTR_CHANNELS*ATTR_WIDTH each  per-vertex channel values; channel k is at [k*ATTR_WIDTH +: ATTR_WIDTH]
- out_valid_o  out  1  output pixel valid
- out_ready_i  in  1  downstream accepts the output
- x_o, y_o  out  POINT_WIDTH each  delayed raster position
- attr_o  out  ATTR_CHANNELS*ATTR_WIDTH  interpolated channels, same packing as the inputs
- factor2_o  out  POINT_WIDTH+1  derived weight of vertex 2, for bezier/debug
- sat_o  out  ATTR_CHANNELS  per-channel flag: result was saturated
- busy_o  out  1  any stage holds a valid pixel

Behaviour:
- Reset (rst_i high, asynchronous): all stage valids 0, out_valid_o=0, busy_o=0, all data outputs 0. in_ready_o=1 once reset is released.
- Pipeline: three register stages, S1 -> S2 -> S3. S3 drives the outputs.
  - Latency: exactly 3 cycles from an accepted input to out_valid_o, with no stall.
  - Throughput: 1 pixel per cycle.
- Advance: en = !out_valid_o || out_ready_i. All stages load together when en=1 and hold when en=0. Bubbles are not compressed.
- in_ready_o = en, combinational from out_ready_i.
- An input is accepted when in_valid_i && in_ready_o.
- S1 (factor stage): register f0={0,factor0_i} and f1={0,factor1_i}, both POINT_WIDTH+1 bits.
  - f2 = 0 if factor0_i+factor1_i >= 2^POINT_WIDTH.
  - Otherwise f2 = 2^POINT_WIDTH - factor0_i - factor1_i.
  - Register x/y and the attributes.
- S2 (multiply stage): register the 3*ATTR_CHANNELS products fi*attri[k].
  - Unsigned channels: unsigned product.
  - Signed channels: $signed({1'b0,fi}) * attri[k].
  - Product width: POINT_WIDTH+ATTR_WIDTH+1.
- S3 (sum stage): sum = p0+p1+p2, with 2 guard bits. result = sum >>> POINT_WIDTH (truncate toward minus infinity).
- Saturation: the shifted result is clamped to the channel range, and sat_o[k]=1 when clamped.
  - Unsigned range: [0, 2^ATTR_WIDTH-1].
  - Signed range: [-2^(ATTR_WIDTH-1), 2^(ATTR_WIDTH-1)-1].
  - Clamping can only occur when factor0_i+factor1_i > 2^POINT_WIDTH.
- Output hold: while out_valid_o && !out_ready_i, every output is stable.
- flush_i: sets all stage valids to 0 next cycle, taking priority over accept. Data registers may keep stale values.
- Simultaneous accept and output handshake in the same cycle is legal; no pixel is lost or duplicated.
- busy_o = S1 valid | S2 valid | S3 valid.

Optional Feature:
- Macro GFX_INTERP_ROUND_EN.
- Defined: S3 adds 2^(POINT_WIDTH-1) to sum before the shift (round half up). Saturation is applied after rounding.
- Undefined: truncation as above; no rounding adder is synthesised.

Test Plan:
- Defaults, factor0=0x8000, factor1=0x4000, channel0 attrs 100/200/400, out_ready_i=1 -> f2=0x4000; 3 cycles later attr_o ch0=200, factor2_o=0x4000, sat_o=0.
- Signed channel (ATTR_SIGNED=1), z0=-1000, z1=2000, z2=0, factor0=factor1=0x8000 -> f2=0, result 500. With factor0=0xFFFF, factor1=0, z all -1 -> result -1 without rounding, -1 with GFX_INTERP_ROUND_EN.
- Overflow: factor0=factor1=0xFFFF, unsigned attrs all 0xFFFF -> f2=0, attr_o=0xFFFF, sat_o[0]=1. Signed attrs all 0x7FFF -> 0x7FFF, sat=1. Signed attrs all 0x8000 -> 0x8000, sat=1.
- Streaming: 8 back-to-back pixels with out_ready_i toggling 1,0,0,1,... -> outputs appear in order with x_o=0..7, no drops or duplicates, outputs stable while stalled.
- flush_i pulsed with 3 pixels in flight -> next cycle busy_o=0 and out_valid_o=0; the next accepted pixel appears 3 cycles after acceptance.
- rst_i asserted mid-stream asynchronously -> out_valid_o and busy_o drop immediately; after release, in_ready_o=1 and the first new pixel has 3-cycle latency.

Source files
------------

// File: rtl/gfx_interp_pipe_if.sv
// Pixel bus for gfx_interp_pipe: upstream pixel/handshake in, interpolated pixel out.
// master = rasteriser/fragment side, slave = the interpolator.
interface gfx_interp_pipe_if #(
    parameter int POINT_WIDTH   = 16,
    parameter int ATTR_CHANNELS = 4,
    parameter int ATTR_WIDTH    = 16
);
    localparam int AV = ATTR_CHANNELS * ATTR_WIDTH;

    logic                     flush_i;
    logic                     in_valid_i;
    logic                     in_ready_o;
    logic [POINT_WIDTH-1:0]   factor0_i;
    logic [POINT_WIDTH-1:0]   factor1_i;
    logic [POINT_WIDTH-1:0]   x_i;
    logic [POINT_WIDTH-1:0]   y_i;
    logic [AV-1:0]            attr0_i;
    logic [AV-1:0]            attr1_i;
    logic [AV-1:0]            attr2_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [POINT_WIDTH-1:0]   x_o;
    logic [POINT_WIDTH-1:0]   y_o;
    logic [AV-1:0]            attr_o;
    logic [POINT_WIDTH:0]     factor2_o;
    logic [ATTR_CHANNELS-1:0] sat_o;
    logic                     busy_o;

    modport master (
        output flush_i, in_valid_i, factor0_i, factor1_i, x_i, y_i,
               attr0_i, attr1_i, attr2_i, out_ready_i,
        input  in_ready_o, out_valid_o, x_o, y_o, attr_o, factor2_o, sat_o, busy_o
    );

    modport slave (
        input  flush_i, in_valid_i, factor0_i, factor1_i, x_i, y_i,
               attr0_i, attr1_i, attr2_i, out_ready_i,
        output in_ready_o, out_valid_o, x_o, y_o, attr_o, factor2_o, sat_o, busy_o
    );
endinterface

// File: rtl/gfx_interp_pipe.sv
// Three-stage barycentric interpolator, one pixel/clock, per-channel signedness + saturation.
// Define GFX_INTERP_ROUND_EN to round half up before the final shift (default: truncate).

// One attribute channel: S1 attr regs, S2 products, S3 sum/shift/clamp.
module gfx_interp_lane #(
    parameter int PW     = 16,
    parameter int AW     = 16,
    parameter bit SIGNED = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [PW:0]   f0_i,
    input  logic [PW:0]   f1_i,
    input  logic [PW:0]   f2_i,
    input  logic [AW-1:0] a0_i,
    input  logic [AW-1:0] a1_i,
    input  logic [AW-1:0] a2_i,
    output logic [AW-1:0] attr_o,
    output logic          sat_o
);
    localparam int PRW = PW + AW + 1;
    localparam int SW  = PRW + 2;

    localparam logic signed [AW+2:0] ONE  = (AW+3)'(1);
    localparam logic signed [AW+2:0] UMAX = (ONE <<< AW) - ONE;
    localparam logic signed [AW+2:0] SMAX = (ONE <<< (AW - 1)) - ONE;
    localparam logic signed [AW+2:0] SMIN = -(ONE <<< (AW - 1));
    localparam logic signed [AW+2:0] HI   = SIGNED ? SMAX : UMAX;
    localparam logic signed [AW+2:0] LO   = SIGNED ? SMIN : '0;

    logic [2:0][AW-1:0]  a_q;
    logic [2:0][PW:0]    f;
    logic [2:0][PRW-1:0] p_q, p_d;
    logic signed [SW-1:0] pe [3];
    logic signed [SW-1:0] sum;
    logic signed [AW+2:0] res;
    logic [AW-1:0]        attr_d, attr_q;
    logic                 sat_d, sat_q;

    assign f = {f2_i, f1_i, f0_i};

    if (SIGNED) begin : g_signed
        always_comb begin
            for (int i = 0; i < 3; i++) begin
                p_d[i] = PRW'($signed({1'b0, f[i]}) * $signed(a_q[i]));
                pe[i]  = SW'($signed(p_q[i]));
            end
        end
    end else begin : g_unsigned
        always_comb begin
            for (int i = 0; i < 3; i++) begin
                p_d[i] = PRW'(f[i] * a_q[i]);
                pe[i]  = SW'(p_q[i]);
            end
        end
    end

`ifdef GFX_INTERP_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(1) << (PW - 1);
    assign sum = pe[0] + pe[1] + pe[2] + $signed(RND);
`else
    assign sum = pe[0] + pe[1] + pe[2];
`endif

    // Dropping the low PW bits of a two's-complement sum floors toward -inf.
    assign res = sum[SW-1:PW];

    always_comb begin
        attr_d = res[AW-1:0];
        sat_d  = 1'b0;
        if (res > HI) begin
            attr_d = HI[AW-1:0];
            sat_d  = 1'b1;
        end else if (res < LO) begin
            attr_d = LO[AW-1:0];
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_q    <= '0;
            p_q    <= '0;
            attr_q <= '0;
            sat_q  <= 1'b0;
        end else if (en_i) begin
            a_q    <= {a2_i, a1_i, a0_i};
            p_q    <= p_d;
            attr_q <= attr_d;
            sat_q  <= sat_d;
        end
    end

    assign attr_o = attr_q;
    assign sat_o  = sat_q;
endmodule

module gfx_interp_pipe #(
    parameter int          POINT_WIDTH   = 16,
    parameter int          ATTR_CHANNELS = 4,
    parameter int          ATTR_WIDTH    = 16,
    parameter logic [15:0] ATTR_SIGNED   = 16'h0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    gfx_interp_pipe_if.slave  bus
);
    localparam int PW     = POINT_WIDTH;
    localparam int AW     = ATTR_WIDTH;
    localparam int AC     = ATTR_CHANNELS;
    localparam int STAGES = 3;
    localparam logic [PW:0] FULL = {1'b1, {PW{1'b0}}};

    typedef struct packed {
        logic [PW-1:0] x;
        logic [PW-1:0] y;
        logic [PW:0]   f2;
    } pass_t;

    logic                en;
    logic [STAGES:1]     vld_pipe_q, vld_pipe_d;
    logic [PW:0]         fsum, f2_d;
    logic [PW:0]         f0_q, f1_q;
    pass_t               s1_d, s1_q, s2_q, s3_q;
    logic [AC-1:0][AW-1:0] attr_w;
    logic [AC-1:0]       sat_w;

    // Whole pipe moves in lockstep; a held S3 freezes everything behind it.
    assign en             = !vld_pipe_q[STAGES] || bus.out_ready_i;
    assign bus.in_ready_o = en;

    always_comb begin
        fsum = {1'b0, bus.factor0_i} + {1'b0, bus.factor1_i};
        f2_d = fsum[PW] ? '0 : FULL - fsum;
        s1_d = '{x: bus.x_i, y: bus.y_i, f2: f2_d};
    end

    always_comb begin
        vld_pipe_d = vld_pipe_q;
        if (bus.flush_i)
            vld_pipe_d = '0;
        else if (en)
            vld_pipe_d = {vld_pipe_q[STAGES-1:1], bus.in_valid_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_pipe_q <= '0;
            f0_q       <= '0;
            f1_q       <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            if (en) begin
                f0_q <= {1'b0, bus.factor0_i};
                f1_q <= {1'b0, bus.factor1_i};
                s1_q <= s1_d;
                s2_q <= s1_q;
                s3_q <= s2_q;
            end
        end
    end

    for (genvar k = 0; k < AC; k++) begin : g_lane
        gfx_interp_lane #(
            .PW     (PW),
            .AW     (AW),
            .SIGNED (ATTR_SIGNED[k])
        ) u_lane (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .en_i   (en),
            .f0_i   (f0_q),
            .f1_i   (f1_q),
            .f2_i   (s1_q.f2),
            .a0_i   (bus.attr0_i[k*AW +: AW]),
            .a1_i   (bus.attr1_i[k*AW +: AW]),
            .a2_i   (bus.attr2_i[k*AW +: AW]),
            .attr_o (attr_w[k]),
            .sat_o  (sat_w[k])
        );
    end

    assign bus.out_valid_o = vld_pipe_q[STAGES];
    assign bus.busy_o      = |vld_pipe_q;
    assign bus.x_o         = s3_q.x;
    assign bus.y_o         = s3_q.y;
    assign bus.factor2_o   = s3_q.f2;
    assign bus.attr_o      = attr_w;
    assign bus.sat_o       = sat_w;
endmodule

// File: tb/tb_gfx_interp_pipe.sv
// Random + directed bench for gfx_interp_pipe against an arithmetic reference model.
// Channels 1 and 3 are signed, 0 and 2 unsigned.
module tb_gfx_interp_pipe;
    localparam int PW = 16;
    localparam int AC = 4;
    localparam int AW = 16;
    localparam logic [15:0] SGN = 16'h000A;

    typedef struct {
        logic [PW-1:0]    x;
        logic [PW-1:0]    y;
        logic [PW:0]      f2;
        logic [AC*AW-1:0] attr;
        logic [AC-1:0]    sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gfx_interp_pipe_if #(.POINT_WIDTH(PW), .ATTR_CHANNELS(AC), .ATTR_WIDTH(AW)) bus ();

    gfx_interp_pipe #(
        .POINT_WIDTH(PW), .ATTR_CHANNELS(AC), .ATTR_WIDTH(AW), .ATTR_SIGNED(SGN)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t q[$];
    int   got_x[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: weighted sum in plain integers, floor-divide, clamp to range.
    function automatic exp_t model(input logic [PW-1:0] f0, input logic [PW-1:0] f1,
                                   input logic [PW-1:0] x, input logic [PW-1:0] y,
                                   input logic [AC*AW-1:0] a0, input logic [AC*AW-1:0] a1,
                                   input logic [AC*AW-1:0] a2);
        exp_t e;
        longint f[3];
        longint s, r, v, hi, lo;
        logic [AC*AW-1:0] a[3];
        logic [AW-1:0] seg;
        a[0] = a0; a[1] = a1; a[2] = a2;
        f[0] = longint'(f0);
        f[1] = longint'(f1);
        f[2] = (f[0] + f[1] >= (longint'(1) <<< PW)) ? 0 : (longint'(1) <<< PW) - f[0] - f[1];
        e.x = x; e.y = y; e.f2 = (PW+1)'(f[2]);
        e.attr = '0; e.sat = '0;
        for (int k = 0; k < AC; k++) begin
            s = 0;
            for (int i = 0; i < 3; i++) begin
                seg = a[i][k*AW +: AW];
                v = SGN[k] ? longint'($signed(seg)) : longint'(seg);
                s += f[i] * v;
            end
`ifdef GFX_INTERP_ROUND_EN
            s += longint'(1) <<< (PW - 1);
`endif
            r  = s >>> PW;
            hi = SGN[k] ? (longint'(1) <<< (AW - 1)) - 1 : (longint'(1) <<< AW) - 1;
            lo = SGN[k] ? -(longint'(1) <<< (AW - 1)) : 0;
            if (r > hi) begin r = hi; e.sat[k] = 1'b1; end
            else if (r < lo) begin r = lo; e.sat[k] = 1'b1; end
            e.attr[k*AW +: AW] = AW'(r);
        end
        return e;
    endfunction

    // Scoreboard holds exactly the pixels inside the pipe, oldest first.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
        end else begin
            chk("in_ready", bus.in_ready_o, !bus.out_valid_o || bus.out_ready_i);
            chk("busy", bus.busy_o, q.size() != 0);
            if (bus.out_valid_o) begin
                if (q.size() == 0) begin
                    chk("out_unexpected", 1, 0);
                end else begin
                    e = q[0];
                    chk("x_o", bus.x_o, e.x);
                    chk("y_o", bus.y_o, e.y);
                    chk("factor2_o", bus.factor2_o, e.f2);
                    chk("attr_o", bus.attr_o, e.attr);
                    chk("sat_o", bus.sat_o, e.sat);
                    if (bus.out_ready_i) begin
                        void'(q.pop_front());
                        got_x.push_back(int'(bus.x_o));
                    end
                end
            end
            if (bus.flush_i)
                q.delete();
            else if (bus.in_valid_i && bus.in_ready_o)
                q.push_back(model(bus.factor0_i, bus.factor1_i, bus.x_i, bus.y_i,
                                  bus.attr0_i, bus.attr1_i, bus.attr2_i));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_px(input int x);
        bus.x_i = PW'(x);
        bus.y_i = PW'($urandom);
        bus.factor0_i = PW'($urandom);
        bus.factor1_i = PW'($urandom);
        for (int k = 0; k < AC; k++) begin
            bus.attr0_i[k*AW +: AW] = AW'($urandom);
            bus.attr1_i[k*AW +: AW] = AW'($urandom);
            bus.attr2_i[k*AW +: AW] = AW'($urandom);
        end
    endtask

    // Single pixel into an empty pipe; check latency and literal result on one channel.
    task automatic run_one(input string nm, input int ch,
                           input logic [PW-1:0] f0, input logic [PW-1:0] f1,
                           input logic [AW-1:0] v0, input logic [AW-1:0] v1, input logic [AW-1:0] v2,
                           input logic [AW-1:0] ea, input logic [PW:0] ef2, input logic es);
        int lat;
        bus.factor0_i = f0; bus.factor1_i = f1;
        bus.x_i = PW'($urandom); bus.y_i = PW'($urandom);
        bus.attr0_i = '0; bus.attr1_i = '0; bus.attr2_i = '0;
        bus.attr0_i[ch*AW +: AW] = v0;
        bus.attr1_i[ch*AW +: AW] = v1;
        bus.attr2_i[ch*AW +: AW] = v2;
        bus.flush_i = 1'b0; bus.out_ready_i = 1'b1; bus.in_valid_i = 1'b1;
        step();
        bus.in_valid_i = 1'b0;
        lat = 1;
        while (!bus.out_valid_o && lat < 10) begin
            step();
            lat++;
        end
        chk({nm, "_latency"}, lat, 3);
        chk({nm, "_attr"}, bus.attr_o[ch*AW +: AW], ea);
        chk({nm, "_f2"}, bus.factor2_o, ef2);
        chk({nm, "_sat"}, bus.sat_o[ch], es);
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int i, cyc, f0i, mode;
        bit acc;

        bus.flush_i = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        bus.factor0_i = '0; bus.factor1_i = '0; bus.x_i = '0; bus.y_i = '0;
        bus.attr0_i = '0; bus.attr1_i = '0; bus.attr2_i = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_attr", bus.attr_o, 0);
        chk("rst_x", bus.x_o, 0);
        chk("rst_f2", bus.factor2_o, 0);
        chk("rst_sat", bus.sat_o, 0);
        #2 rst = 1'b0;
        #1 chk("rst_in_ready", bus.in_ready_o, 1);

        // Directed literal cases
        run_one("basic", 0, 16'h8000, 16'h4000, 16'd100, 16'd200, 16'd400, 16'd200, 17'h04000, 1'b0);
        run_one("signed", 1, 16'h8000, 16'h8000, 16'hFC18, 16'h07D0, 16'h0000, 16'h01F4, 17'h00000, 1'b0);
        run_one("neg1", 1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 17'h00001, 1'b0);
        run_one("ovf_u", 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 17'h00000, 1'b1);
        run_one("ovf_sp", 1, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 17'h00000, 1'b1);
        run_one("ovf_sn", 1, 16'hFFFF, 16'hFFFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 17'h00000, 1'b1);
        run_one("sum_full", 0, 16'hC000, 16'h4000, 16'd1000, 16'd3000, 16'd7, 16'd1500, 17'h00000, 1'b0);

        // Streaming with stalls 1,0,0,1,...
        got_x.delete();
        i = 0; cyc = 0;
        while (i < 8 && cyc < 200) begin
            bus.out_ready_i = pat[cyc % 4];
            rand_px(i);
            bus.in_valid_i = 1'b1;
            @(negedge clk);
            acc = bus.in_ready_o;
            step();
            if (acc) i++;
            cyc++;
        end
        bus.in_valid_i = 1'b0;
        while (q.size() != 0 && cyc < 400) begin
            bus.out_ready_i = pat[cyc % 4];
            step();
            cyc++;
        end
        bus.out_ready_i = 1'b1;
        step();
        chk("stream_count", got_x.size(), 8);
        for (int j = 0; j < 8; j++)
            chk("stream_order", (j < got_x.size()) ? got_x[j] : -1, j);

        // Randomised traffic with back-pressure, flushes and factor edge cases
        for (int c = 0; c < 400; c++) begin
            rand_px(c);
            mode = int'($urandom_range(0, 3));
            case (mode)
                1: begin
                    f0i = int'($urandom_range(0, 65535));
                    bus.factor0_i = PW'(f0i);
                    bus.factor1_i = PW'($urandom_range(0, 65535 - f0i));
                end
                2: begin
                    bus.factor0_i = PW'($urandom_range(49152, 65535));
                    bus.factor1_i = PW'($urandom_range(49152, 65535));
                end
                3: begin
                    f0i = int'($urandom_range(1, 65535));
                    bus.factor0_i = PW'(f0i);
                    bus.factor1_i = PW'(65536 - f0i);
                end
                default: ;
            endcase
            bus.in_valid_i  = ($urandom_range(0, 2) != 0);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            bus.flush_i     = ($urandom_range(0, 49) == 0);
            step();
        end
        bus.in_valid_i = 1'b0; bus.flush_i = 1'b0; bus.out_ready_i = 1'b1;
        repeat (5) step();

        // Flush with three pixels in flight
        for (int j = 0; j < 3; j++) begin
            rand_px(100 + j);
            bus.in_valid_i = 1'b1;
            step();
        end
        bus.in_valid_i = 1'b0;
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        chk("flush_busy", bus.busy_o, 0);
        chk("flush_out_valid", bus.out_valid_o, 0);
        run_one("post_flush", 0, 16'h8000, 16'h4000, 16'd100, 16'd200, 16'd400, 16'd200, 17'h04000, 1'b0);

        // Asynchronous reset mid-stream
        for (int j = 0; j < 2; j++) begin
            rand_px(200 + j);
            bus.in_valid_i = 1'b1;
            step();
        end
        bus.in_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", bus.out_valid_o, 0);
        chk("arst_busy", bus.busy_o, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("arst_in_ready", bus.in_ready_o, 1);
        run_one("post_rst", 1, 16'h8000, 16'h8000, 16'hFC18, 16'h07D0, 16'h0000, 16'h01F4, 17'h00000, 1'b0);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
